// File: rtl/ahb_default_slave.sv
// AHB default slave: zero-wait OKAY for IDLE/BUSY, WAIT_CYCLES OKAY waits then a two-cycle ERROR for active transfers.
// Completes an active transfer WAIT_CYCLES+2 cycles after acceptance; holds hreadyout low through waits and ERR1.
module ahb_default_slave #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int WAIT_CYCLES    = 0,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic [1:0]                hresp,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [2:0]                err_size,
  output logic [CNT_WIDTH-1:0]      err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic [1:0]           RESP_OKAY  = 2'b00;
  localparam logic [1:0]           RESP_ERROR = 2'b01;
  localparam bit                   HAS_WAIT   = (WAIT_CYCLES > 0);
  localparam logic [3:0]           WAIT_LOAD  = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  state_t                    r_state;
  logic [3:0]                r_wcnt;
  logic                      r_hreadyout;
  logic [1:0]                r_hresp;
  logic [AHB_ADDR_WIDTH-1:0] r_sh_addr;
  logic                      r_sh_write;
  logic [2:0]                r_sh_size;
  logic                      r_err_valid;
  logic [AHB_ADDR_WIDTH-1:0] r_err_addr;
  logic                      r_err_write;
  logic [2:0]                r_err_size;
  logic [CNT_WIDTH-1:0]      r_err_count;

  logic w_act;
  logic w_take;
  logic w_err_done;

  // Only NONSEQ/SEQ (htrans[1] set) count as active transfers.
  assign w_act      = hsel & hready & htrans[1];
  assign w_take     = w_act & ((r_state == ST_IDLE) | (r_state == ST_ERR2));
  assign w_err_done = (r_state == ST_ERR1);

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          if (w_act) begin
            r_hreadyout <= 1'b0;
            if (HAS_WAIT) begin
              r_state <= ST_WAIT;
              r_wcnt  <= WAIT_LOAD;
              r_hresp <= RESP_OKAY;
            end else begin
              r_state <= ST_ERR1;
              r_hresp <= RESP_ERROR;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= RESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= RESP_ERROR;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_ERROR;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= RESP_OKAY;
        end
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_sh_addr  <= '0;
      r_sh_write <= 1'b0;
      r_sh_size  <= 3'd0;
    end else if (w_take) begin
      r_sh_addr  <= haddr;
      r_sh_write <= hwrite;
      r_sh_size  <= hsize;
    end
  end

  // First error wins, unless a clear lands on the same edge as a new error.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
      r_err_size  <= 3'd0;
      r_err_count <= '0;
    end else if (w_err_done) begin
      if (!r_err_valid || err_clr) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= r_sh_addr;
        r_err_write <= r_sh_write;
        r_err_size  <= r_sh_size;
      end
      if (err_clr) begin
        r_err_count <= CNT_ONE;
      end else if (r_err_count != CNT_MAX) begin
        r_err_count <= r_err_count + CNT_ONE;
      end
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_write <= 1'b0;
      r_err_size  <= 3'd0;
      r_err_count <= '0;
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_write = r_err_write;
  assign err_size  = r_err_size;
  assign err_count = r_err_count;

endmodule
